ram_arbiter: RTL
================

# ram_arbiter

Two-requester arbiter and sequencer for the 32Kx16 byte-addressable main RAM. It shares the RAM between the CPU bus port (port 0) and the DMA/peripheral port (port 1) using round-robin grant. It runs the single-cycle RAM access and returns registered read data with a one-cycle acknowledge pulse. It traps odd-address word accesses before they reach the RAM.

## Interface
Parameters:
- ADDR_W, 16: byte address width; RAM word address is addr[15:1].
- DATA_W, 16: data width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req[1:0]  in  2  per-port request, level, held until ack.
- addr0, addr1  in  16  per-port byte address.
- wdata0, wdata1  in  16  per-port write data; byte writes use bits [7:0].
- we[1:0]  in  2  per-port write enable (1 = write).
- byte_op[1:0]  in  2  per-port byte access.
- ack[1:0]  out  2  one-cycle completion pulse per port.
- err[1:0]  out  2  valid with ack; 1 = odd-address word access, no RAM cycle.
- rdata  out  16  registered read data, valid in the ack cycle of a read.
- ram_addr  out  16  RAM byte address.
- ram_di  out  16  RAM write data.
- ram_do  in  16  RAM read data; asynchronous/combinational.
- ram_ce_n  out  1  RAM chip enable, active low.
- ram_we_n  out  1  RAM write enable, active low.
- ram_byte_op  out  1  RAM byte mode.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any eligible req is set, pick the winner. Latch its addr, wdata, we and byte_op into internal registers, then go to ACCESS. If no request, stay in IDLE.
- Round-robin rule: `last` register holds the most recently granted port (reset = 1, so port 0 wins the first tie). On simultaneous requests, the port ≠ `last` wins. `last` updates on every grant.
- Odd-address check at grant: if byte_op = 0 and addr[0] = 1, latch the error flag. ACCESS then drives ram_ce_n = 1 (no RAM cycle) and reports err in DONE.
- ACCESS, normal: ram_ce_n = 0 and ram_we_n = ~we_latched. The RAM address, data and byte_op outputs come from the latched values. The RAM writes on the closing edge. On that same edge, rdata <= ram_do for reads; for writes rdata holds its previous value.
- DONE: ack[g] = 1 for the granted port g, and err[g] = the latched error. In the same cycle the arbiter evaluates requests, excluding port g (its req is still high in this cycle). If the other port requests, grant it and go directly to ACCESS; otherwise go to IDLE.
- Requesters may keep req high after ack to issue a new access. They must present the new addr/data from the cycle after ack.
- Byte lane placement (high/low byte, zero-extension on reads) is done by the RAM. The arbiter passes byte_op and addr through unchanged.
- Outside ACCESS: ram_ce_n = 1, ram_we_n = 1. The other RAM outputs hold their last latched values.

## Timing
- Reset values: state = IDLE; ack = 0; err = 0; rdata = 0; ram_ce_n = 1; ram_we_n = 1; ram_addr = 0; ram_di = 0; ram_byte_op = 0; last = 1.
- Latency: req seen in IDLE at cycle N, ACCESS at N+1, ack at N+2.
- Back-to-back alternating ports: one access every 2 cycles (ACCESS, DONE, ACCESS, …).
- A single port re-requesting: every 3 cycles, because it must pass through IDLE.
- ram_we_n is low for exactly one cycle per write, with address and data stable for the whole cycle.
- Async reset in ACCESS: ram_we_n and ram_ce_n go high immediately. The write is not guaranteed and no ack is issued.
- req dropped before ack: undefined requester behaviour. The arbiter completes the latched access and still pulses ack.

## Structure
- Package ram_arb_pkg holds:
  - state enum {IDLE, ACCESS, DONE};
  - localparams PORT_CPU = 0 and PORT_DMA = 1.
- Sub-module rr_arb2: combinational two-way round-robin pick. Inputs are req[1:0], last and an exclude mask; outputs are gnt_valid and gnt_idx. The main FSM instantiates it once.

## Test plan
- Reset, then idle: all outputs at their reset values; ram_ce_n stays 1 for 10 cycles with req = 0.
- Port 0 word write: addr 0o000700, data 0o012706; then a read of the same address. Required: ack0 at N+2, then rdata = 0o012706.
- Byte write: port 1 byte write of 0x5A to 0o000701 over an existing 0x1234 at 0o000700. A word read returns 0x5A34; a byte read of 0o000701 returns 0x005A.
- Simultaneous requests from both ports, held for 4 accesses: grants alternate 0, 1, 0, 1. After the first grant, each ack comes 2 cycles after the previous one.
- Odd word access: word read at 0o000501. ack with err = 1, and ram_ce_n never goes low.
- Async reset mid-ACCESS of a write: ram_we_n returns to 1 within the reset cycle, there is no ack, and state = IDLE after reset release.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the main-RAM arbiter.
// Ports are numbered by requester: the CPU bus is port 0 and the DMA/peripheral port is port 1.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int PORT_CPU = 0;
   localparam int PORT_DMA = 1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
// When both eligible ports request, the port that was not granted last wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic [1:0] excl,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   logic [1:0] elig;

   assign elig      = req & ~excl;
   assign gnt_valid = |elig;
   assign gnt_idx   = (elig == 2'b11) ? ~last : elig[1];

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter and single-cycle sequencer for the 32Kx16 main RAM.
// Odd-address word accesses are trapped at grant and complete with err instead of a RAM cycle.
//
//   state  | meaning
//   IDLE   | no access in flight; grant any requester
//   ACCESS | RAM cycle on latched request (suppressed if trapped)
//   DONE   | ack/err to granted port; may grant the other port directly
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        req,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [1:0]        we,
   input  logic [1:0]        byte_op,
   output logic [1:0]        ack,
   output logic [1:0]        err,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_di,
   input  logic [DATA_W-1:0] ram_do,
   output logic              ram_ce_n,
   output logic              ram_we_n,
   output logic              ram_byte_op
);

   state_t            state_q, state_d;
   logic              last_q;
   logic              gnt_q;
   logic              we_q;
   logic              err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              byte_q;
   logic [DATA_W-1:0] rdata_q;

   logic [1:0]        excl;
   logic              gnt_valid;
   logic              gnt_idx;
   logic              load;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_we;
   logic              sel_byte;
   logic              ram_cycle;
   logic [1:0]        gnt_onehot;

   // The port just acknowledged still holds req in DONE, so mask it out.
   assign excl = (state_q == DONE) ? gnt_onehot : 2'b00;

   rr_arb2 u_rr_arb2 (
      .req       (req),
      .last      (last_q),
      .excl      (excl),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   assign load      = gnt_valid && (state_q == IDLE || state_q == DONE);
   assign sel_addr  = gnt_idx ? addr1  : addr0;
   assign sel_wdata = gnt_idx ? wdata1 : wdata0;
   assign sel_we    = gnt_idx ? we[1]      : we[0];
   assign sel_byte  = gnt_idx ? byte_op[1] : byte_op[0];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (gnt_valid) state_d = ACCESS;
         ACCESS:  state_d = DONE;
         DONE:    state_d = gnt_valid ? ACCESS : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         byte_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            last_q  <= gnt_idx;
            gnt_q   <= gnt_idx;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            we_q    <= sel_we;
            byte_q  <= sel_byte;
            err_q   <= ~sel_byte & sel_addr[0];
         end
         if (ram_cycle && !we_q) rdata_q <= ram_do;
      end
   end

   assign ram_cycle   = (state_q == ACCESS) && !err_q;
   assign gnt_onehot  = gnt_q ? 2'b10 : 2'b01;

   assign ack         = (state_q == DONE) ? gnt_onehot : 2'b00;
   assign err         = (state_q == DONE && err_q) ? gnt_onehot : 2'b00;
   assign rdata       = rdata_q;
   assign ram_addr    = addr_q;
   assign ram_di      = wdata_q;
   assign ram_byte_op = byte_q;
   assign ram_ce_n    = ~ram_cycle;
   assign ram_we_n    = ~(ram_cycle && we_q);

endmodule
